brushless_pwm_drv: RTL and testbench

BRUSHLESS_PWM_DRV -- requirements
Module: brushless_pwm_drv

---
 rtl/brushless_pwm_drv.sv | 136 +++++++++++++
 tb/tb_brushless_pwm_drv.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/brushless_pwm_drv.sv
// rtl/brushless_pwm_drv.sv - BLDC six-step PWM gate driver with shared dead-time interlock
module brushless_pwm_drv #(
  parameter int DEAD_TIME = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] drv_mag,
  input  logic        hallGrn,
  input  logic        hallYlw,
  input  logic        hallBlu,
  input  logic        brake_n,
  output logic        PWM_synch,
  output logic        highGrn,
  output logic        lowGrn,
  output logic        highYlw,
  output logic        lowYlw,
  output logic        highBlu,
  output logic        lowBlu
);

  typedef enum logic [1:0] {
    PH_FLOAT = 2'd0,
    PH_PWM   = 2'd1,
    PH_LOW   = 2'd2
  } phase_mode_t;

  localparam logic [5:0] DT_LOAD = 6'(DEAD_TIME);

  logic [10:0] cnt;
  logic [10:0] duty_q;
  logic [1:0]  sync_grn, sync_ylw, sync_blu;
  logic [2:0]  rot, rot_q;
  logic        pwm_raw, pwm_q, brake_q;
  logic        trig;
  logic [5:0]  dt_cnt, dt_next;
  logic [5:0]  drive;
  logic        drv_mag_unused;
  phase_mode_t mode_grn, mode_ylw, mode_blu;

  // Duty is half-resolution of the 12-bit magnitude; the LSB is dropped on purpose.
  assign drv_mag_unused = drv_mag[0];

  // PWM_synch is registered one count early so it is high exactly while cnt==2047.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      PWM_synch <= 1'b0;
      duty_q    <= '0;
    end else begin
      cnt       <= cnt + 11'd1;
      PWM_synch <= (cnt == 11'd2046);
      if (PWM_synch) duty_q <= drv_mag[11:1];
    end
  end

  // Two-flop synchronizers on hall inputs; rotor state sampled only at period end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_grn <= '0;
      sync_ylw <= '0;
      sync_blu <= '0;
      rot      <= '0;
    end else begin
      sync_grn <= {sync_grn[0], hallGrn};
      sync_ylw <= {sync_ylw[0], hallYlw};
      sync_blu <= {sync_blu[0], hallBlu};
      if (PWM_synch) rot <= {sync_grn[1], sync_ylw[1], sync_blu[1]};
    end
  end

  assign pwm_raw = (cnt < duty_q);

  // Six-step commutation table; 000 and 111 leave every phase floating.
  always_comb begin
    mode_grn = PH_FLOAT;
    mode_ylw = PH_FLOAT;
    mode_blu = PH_FLOAT;
    case (rot)
      3'b101:  begin mode_grn = PH_PWM;  mode_ylw = PH_LOW;  end
      3'b100:  begin mode_grn = PH_PWM;  mode_blu = PH_LOW;  end
      3'b110:  begin mode_ylw = PH_PWM;  mode_blu = PH_LOW;  end
      3'b010:  begin mode_grn = PH_LOW;  mode_ylw = PH_PWM;  end
      3'b011:  begin mode_grn = PH_LOW;  mode_blu = PH_PWM;  end
      3'b001:  begin mode_ylw = PH_LOW;  mode_blu = PH_PWM;  end
      default: ;
    endcase
  end

  function automatic logic [1:0] phase_drive(input phase_mode_t m, input logic pwm,
                                             input logic brk_n);
    logic [1:0] hl;
    hl = 2'b00;
    if (!brk_n) hl = 2'b01;
    else if (m == PH_PWM) hl = {pwm, ~pwm};
    else if (m == PH_LOW) hl = 2'b01;
    phase_drive = hl;
  endfunction

  // Target gate pattern and dead-time restart on any change of PWM level, rotor state or brake.
  always_comb begin
    drive = {phase_drive(mode_grn, pwm_raw, brake_n),
             phase_drive(mode_ylw, pwm_raw, brake_n),
             phase_drive(mode_blu, pwm_raw, brake_n)};
    trig  = (pwm_raw != pwm_q) || (rot != rot_q) || (brake_n != brake_q);
    if (trig)                dt_next = DT_LOAD;
    else if (dt_cnt != 6'd0) dt_next = dt_cnt - 6'd1;
    else                     dt_next = 6'd0;
  end

  // Previous-cycle copies used for change detection, plus the shared dead-time counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_q   <= 1'b0;
      rot_q   <= '0;
      brake_q <= 1'b1;
      dt_cnt  <= '0;
    end else begin
      pwm_q   <= pwm_raw;
      rot_q   <= rot;
      brake_q <= brake_n;
      dt_cnt  <= dt_next;
    end
  end

  // Gate register: held low whenever the dead-time interval is still running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {highGrn, lowGrn, highYlw, lowYlw, highBlu, lowBlu} <= '0;
    end else if (dt_next != 6'd0) begin
      {highGrn, lowGrn, highYlw, lowYlw, highBlu, lowBlu} <= '0;
    end else begin
      {highGrn, lowGrn, highYlw, lowYlw, highBlu, lowBlu} <= drive;
    end
  end

endmodule

// File: tb/tb_brushless_pwm_drv.sv
// tb/tb_brushless_pwm_drv.sv - scoreboard bench for brushless_pwm_drv
module tb_brushless_pwm_drv;
  localparam int D = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] drv_mag = '0;
  logic        hall_grn = 1'b0, hall_ylw = 1'b0, hall_blu = 1'b0;
  logic        brake_n = 1'b1;
  logic        pwm_synch;
  logic        high_grn, low_grn, high_ylw, low_ylw, high_blu, low_blu;

  always #5 clk = ~clk;

  brushless_pwm_drv #(.DEAD_TIME(D)) dut (
    .clk(clk), .rst_n(rst_n), .drv_mag(drv_mag),
    .hallGrn(hall_grn), .hallYlw(hall_ylw), .hallBlu(hall_blu), .brake_n(brake_n),
    .PWM_synch(pwm_synch),
    .highGrn(high_grn), .lowGrn(low_grn), .highYlw(high_ylw), .lowYlw(low_ylw),
    .highBlu(high_blu), .lowBlu(low_blu)
  );

  typedef struct {
    string tag;
    int    val;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cnt_out[6];
  int   zeros, first_nz, synch_cnt, synch_last;

  function automatic logic [5:0] gates();
    return {high_grn, low_grn, high_ylw, low_ylw, high_blu, low_blu};
  endfunction

  task automatic push(input string tag, input int val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic pop_check(input int actual);
    exp_t e;
    if (sb.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty: observed %0d expected none", actual);
    end else begin
      e = sb.pop_front();
      vectors++;
      assert (actual === e.val) else begin
        miscompares++;
        $error("FAIL %s: observed %0d expected %0d", e.tag, actual, e.val);
      end
    end
  endtask

  // Phase mode from the commutation table: 0 float, 1 pwm, 2 low; ph 0=Grn 1=Ylw 2=Blu.
  function automatic int mode_of(input logic [2:0] r, input int ph);
    logic [5:0] m;
    case (r)
      3'b101:  m = {2'd1, 2'd2, 2'd0};
      3'b100:  m = {2'd1, 2'd0, 2'd2};
      3'b110:  m = {2'd0, 2'd1, 2'd2};
      3'b010:  m = {2'd2, 2'd1, 2'd0};
      3'b011:  m = {2'd2, 2'd0, 2'd1};
      3'b001:  m = {2'd0, 2'd2, 2'd1};
      default: m = 6'd0;
    endcase
    return int'(m[(2 - ph) * 2 +: 2]);
  endfunction

  // All-zero samples over cnt 1..2047 for a legal pattern with duty d (d >= D).
  function automatic int zero_cycles(input int d, input bit trig0);
    int z;
    z = trig0 ? D : 0;
    if (d > 0 && d < 2047) z += ((2047 - d) < D) ? (2047 - d) : D;
    return z;
  endfunction

  function automatic int exp_count(input int mode, input bit hi, input int d, input bit trig0);
    int v;
    v = 0;
    if (mode == 1) begin
      if (hi) v = (d > 0) ? d - D : 0;
      else if (d == 0) v = 2047 - (trig0 ? D : 0);
      else v = (2047 - d - D > 0) ? 2047 - d - D : 0;
    end else if (mode == 2) begin
      v = hi ? 0 : 2047 - zero_cycles(d, trig0);
    end
    return v;
  endfunction

  // Observe one full period starting from a PWM_synch negedge; sample k equals cnt k.
  task automatic measure(input int chg_idx, input logic [11:0] mag, input logic [2:0] hall,
                         input logic brk);
    logic [5:0] g;
    for (int j = 0; j < 6; j++) cnt_out[j] = 0;
    zeros = 0; first_nz = -1; synch_cnt = 0; synch_last = 0;
    for (int k = 0; k < 2048; k++) begin
      @(negedge clk);
      g = gates();
      if (k >= 1) begin
        for (int j = 0; j < 6; j++) cnt_out[j] += int'(g[5 - j]);
        if (g == 6'd0) zeros++;
        else if (first_nz < 0) first_nz = k;
      end
      if (pwm_synch) synch_cnt++;
      if (k == 2047) synch_last = int'(pwm_synch);
      if (k == chg_idx) begin
        drv_mag = mag;
        {hall_grn, hall_ylw, hall_blu} = hall;
        brake_n = brk;
      end
    end
  endtask

  task automatic check_period(input logic [2:0] r, input int d, input bit first);
    bit    trig0, legal;
    string nm[6];
    nm = '{"highGrn", "lowGrn", "highYlw", "lowYlw", "highBlu", "lowBlu"};
    trig0 = first || (d > 0);
    legal = (r != 3'b000) && (r != 3'b111);
    for (int j = 0; j < 6; j++)
      push($sformatf("rot%03b_d%0d_%s_count", r, d, nm[j]),
           exp_count(mode_of(r, j / 2), (j % 2) == 0, d, trig0));
    push($sformatf("rot%03b_d%0d_zero_cycles", r, d), legal ? zero_cycles(d, trig0) : 2047);
    push($sformatf("rot%03b_d%0d_first_drive", r, d), legal ? D + 1 : -1);
    push($sformatf("rot%03b_d%0d_synch_count", r, d), 1);
    push($sformatf("rot%03b_d%0d_synch_at_2047", r, d), 1);
    for (int j = 0; j < 6; j++) pop_check(cnt_out[j]);
    pop_check(zeros);
    pop_check(first_nz);
    pop_check(synch_cnt);
    pop_check(synch_last);
  endtask

  task automatic wait_synch(output int n);
    n = -1;
    for (int i = 1; i <= 5000; i++) begin
      @(negedge clk);
      if (pwm_synch) begin
        n = i;
        break;
      end
    end
  endtask

  // Shoot-through guard on every sampled cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      logic overlap;
      overlap = (high_grn & low_grn) | (high_ylw & low_ylw) | (high_blu & low_blu);
      vectors++;
      assert (overlap === 1'b0) else begin
        miscompares++;
        $error("FAIL shoot_through: observed gates %06b expected no phase high and low", gates());
      end
    end
  end

  // Directed sequence.
  initial begin
    int         n, zc;
    logic [5:0] g;
    logic [2:0] sweep[7];
    logic [2:0] prev;
    sweep = '{3'b110, 3'b010, 3'b011, 3'b001, 3'b101, 3'b000, 3'b111};

    repeat (4) @(negedge clk);
    push("reset_outputs", 0);
    pop_check(int'({pwm_synch, gates()}));
    rst_n = 1'b1;
    wait_synch(n);
    push("first_synch_latency", 2047);
    pop_check(n);

    measure(2040, 12'h800, 3'b101, 1'b1);
    check_period(3'b000, 1024, 1'b0);
    measure(-1, 12'h800, 3'b101, 1'b1);
    check_period(3'b101, 1024, 1'b1);
    measure(2040, 12'h200, 3'b101, 1'b1);
    check_period(3'b101, 1024, 1'b0);

    measure(500, 12'hC00, 3'b101, 1'b1);
    check_period(3'b101, 256, 1'b0);
    measure(2040, 12'h800, 3'b100, 1'b1);
    check_period(3'b101, 1536, 1'b0);

    prev = 3'b100;
    for (int i = 0; i < 7; i++) begin
      measure(2040, 12'h800, sweep[i], 1'b1);
      check_period(prev, 1024, 1'b1);
      prev = sweep[i];
    end
    measure(2040, 12'hFFF, 3'b110, 1'b1);
    check_period(3'b111, 1024, 1'b1);
    measure(-1, 12'hFFF, 3'b110, 1'b1);
    check_period(3'b110, 2047, 1'b1);

    repeat (400) @(negedge clk);
    brake_n = 1'b0;
    zc = 0;
    for (int k = 0; k < D; k++) begin
      @(negedge clk);
      if (gates() == 6'd0) zc++;
    end
    @(negedge clk);
    g = gates();
    push("brake_dead_zeros", D);
    pop_check(zc);
    push("brake_pattern", 6'b010101);
    pop_check(int'(g));
    repeat (100) @(negedge clk);
    brake_n = 1'b1;
    zc = 0;
    for (int k = 0; k < D; k++) begin
      @(negedge clk);
      if (gates() == 6'd0) zc++;
    end
    @(negedge clk);
    g = gates();
    push("release_dead_zeros", D);
    pop_check(zc);
    push("release_pattern", 6'b001001);
    pop_check(int'(g));

    wait_synch(n);
    push("resync_after_brake", 1);
    pop_check(int'(n > 0));
    measure(2040, 12'h000, 3'b011, 1'b1);
    measure(2040, 12'hFFF, 3'b011, 1'b1);
    check_period(3'b011, 0, 1'b1);
    measure(-1, 12'hFFF, 3'b011, 1'b1);
    check_period(3'b011, 2047, 1'b0);

    for (int i = 0; i < 150; i++) begin
      drv_mag = 12'($urandom_range(0, 4095));
      {hall_grn, hall_ylw, hall_blu} = 3'($urandom_range(0, 7));
      brake_n = ($urandom_range(0, 3) != 0);
      repeat (20) @(negedge clk);
    end

    brake_n = 1'b1;
    repeat (3) @(negedge clk);
    brake_n = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    push("reset_in_dead_time", 0);
    pop_check(int'({pwm_synch, gates()}));

    @(negedge clk);
    drv_mag = 12'h800;
    {hall_grn, hall_ylw, hall_blu} = 3'b101;
    brake_n = 1'b1;
    rst_n = 1'b1;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (high_grn) break;
    end
    push("high_grn_before_reset", 1);
    pop_check(int'(high_grn));
    #2 rst_n = 1'b0;
    #1;
    push("reset_while_high", 0);
    pop_check(int'({pwm_synch, gates()}));
    @(negedge clk);
    rst_n = 1'b1;
    wait_synch(n);
    push("synch_latency_after_reset", 2047);
    pop_check(n);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
